jtkunio_pcm_fetch: RTL and testbench

Prefetch stage between the sound board's ADPCM sequencer and the SDRAM PCM ROM port. On a start pulse it streams one 2^SEGW-byte segment from ROM into a 2-byte buffer. It delivers one 4-bit nibble per request to the MSM5205-style decoder, high nibble first, and pulses done after the last nibble. It hides SDRAM latency that the decoder's fixed nibble rate cannot tolerate.

---
 rtl/jtkunio_pcm_fetch_pkg.sv | 15 +
 rtl/jtkunio_pcm_fetch_if.sv | 17 +
 rtl/jtkunio_pcm_fifo2.sv | 45 ++++
 rtl/jtkunio_pcm_fetch.sv | 113 +++++++++++
 tb/tb_jtkunio_pcm_fetch.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/jtkunio_pcm_fetch_pkg.sv
// Shared definitions for the kunio PCM prefetch stage: FSM encoding and
// default ROM geometry.
package jtkunio_pcm_fetch_pkg;

  localparam int KUNIO_AW   = 17;
  localparam int KUNIO_SEGW = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

endpackage

// File: rtl/jtkunio_pcm_fetch_if.sv
// SDRAM PCM ROM read port: the fetch stage drives address/chip-select,
// the SDRAM controller returns a byte qualified by ok.
interface jtkunio_pcm_fetch_if
  import jtkunio_pcm_fetch_pkg::*;
#(
  parameter int AW = KUNIO_AW
);

  logic [AW-1:0] addr;
  logic          cs;
  logic [7:0]    data;
  logic          ok;

  modport master (output addr, cs, input data, ok);
  modport slave  (input addr, cs, output data, ok);

endinterface

// File: rtl/jtkunio_pcm_fifo2.sv
// Two-entry byte FIFO with synchronous clear; a push and pop in the same
// cycle leave the occupancy unchanged.
module jtkunio_pcm_fifo2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; cnt alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtkunio_pcm_fetch.sv
// ADPCM prefetch: streams one ROM segment into a 2-byte buffer and hands
// out one nibble per decoder request, high nibble first.
module jtkunio_pcm_fetch
  import jtkunio_pcm_fetch_pkg::*;
#(
  parameter int AW   = KUNIO_AW,
  parameter int SEGW = KUNIO_SEGW
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic [AW-SEGW-1:0] base,
  input  logic               nib_req,
  output logic [3:0]         nib_dout,
  output logic               underrun,
  output logic               busy,
  output logic               done,
  jtkunio_pcm_fetch_if.master rom
);

  state_t             state, state_nx;
  logic [AW-SEGW-1:0] base_q;
  logic [SEGW-1:0]    fetch_addr;
  logic [SEGW:0]      nib_cnt;
  logic               addr_stable;

  logic       accept, serve, pop, complete, full_nx;
  logic [7:0] head;
  logic       full, empty;

  assign rom.addr = {base_q, fetch_addr};
  assign rom.cs   = (state == ST_FETCH);
  assign busy     = (state != ST_IDLE);

  // An ok seen on the first cycle of a new address may belong to the old one.
  assign accept   = rom.cs && rom.ok && addr_stable && !full && !start && !stop;
  assign serve    = nib_req && busy && !start && !stop;
  assign pop      = serve && !empty && nib_cnt[0];
  assign complete = serve && !empty && (&nib_cnt);
  assign full_nx  = !empty && accept && !pop;

  jtkunio_pcm_fifo2 u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (start || stop),
    .push  (accept),
    .din   (rom.data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // NOTE: next state takes its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ST_FETCH;
    end else if (stop || complete) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_FETCH: if (accept) begin
          if (&fetch_addr)  state_nx = ST_TAIL;
          else if (full_nx) state_nx = ST_WAIT;
        end
        ST_WAIT:  if (!full) state_nx = ST_FETCH;
        default: ;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      base_q      <= '0;
      fetch_addr  <= '0;
      nib_cnt     <= '0;
      addr_stable <= 1'b0;
      nib_dout    <= 4'd0;
      underrun    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= complete;
      if (start) begin
        base_q      <= base;
        fetch_addr  <= '0;
        nib_cnt     <= '0;
        underrun    <= 1'b0;
        addr_stable <= 1'b0;
      end else begin
        addr_stable <= !accept;
        if (accept) fetch_addr <= fetch_addr + SEGW'(1);
        if (serve) begin
          if (empty) begin
            nib_dout <= 4'd0;
            underrun <= 1'b1;
          end else begin
            nib_dout <= nib_cnt[0] ? head[3:0] : head[7:4];
            nib_cnt  <= nib_cnt + (SEGW+1)'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtkunio_pcm_fetch.sv
// Randomized bench for jtkunio_pcm_fetch: a latency-modelled ROM and a
// nibble-index reference model of the expected decoder stream.
module tb_jtkunio_pcm_fetch;

  localparam int AW   = 17;
  localparam int SEGW = 3;
  localparam int BW   = AW - SEGW;
  localparam int NNIB = 1 << (SEGW + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          nib_req = 1'b0;
  logic [BW-1:0] base = '0;
  logic [3:0]    nib_dout;
  logic          underrun, busy, done;

  jtkunio_pcm_fetch_if #(.AW(AW)) rom_if ();

  jtkunio_pcm_fetch #(.AW(AW), .SEGW(SEGW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .base     (base),
    .nib_req  (nib_req),
    .nib_dout (nib_dout),
    .underrun (underrun),
    .busy     (busy),
    .done     (done),
    .rom      (rom_if)
  );

  always #5 clk = ~clk;

  // ROM: data registered from the address, ok after rom_lat stable cycles
  int          rom_lat = 2;
  logic        force_ok = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int          stable_cnt = 0;

  always @(posedge clk) begin
    rom_if.data <= rom_if.addr[7:0] ^ 8'hA5;
    if (rom_if.addr != prev_addr) begin
      stable_cnt <= 0;
      rom_if.ok  <= force_ok;
    end else begin
      stable_cnt <= stable_cnt + 1;
      rom_if.ok  <= force_ok || (stable_cnt + 1 >= rom_lat);
    end
    prev_addr <= rom_if.addr;
  end

  int done_cnt = 0;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  int total = 0;
  int bad = 0;
  int exp_done = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_nib(input int b, input int k);
    int a, byt;
    a   = b * (1 << SEGW) + k / 2;
    byt = (a % 256) ^ 'hA5;
    return (k % 2 == 1) ? (byt % 16) : (byt / 16);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input bit with_req, input bit with_stop);
    start   = 1'b1;
    base    = BW'(b);
    nib_req = with_req;
    stop    = with_stop;
    tick(1);
    start   = 1'b0;
    nib_req = 1'b0;
    stop    = 1'b0;
    check("start_busy", busy, 1);
    check("start_cs", rom_if.cs, 1);
    check("start_addr", rom_if.addr, b * (1 << SEGW));
    check("start_underrun", underrun, 0);
  endtask

  task automatic req_nib();
    nib_req = 1'b1;
    tick(1);
    nib_req = 1'b0;
  endtask

  task automatic play(input int b, input int k0, input int exp_ur);
    for (int k = k0; k < NNIB; k++) begin
      tick($urandom_range(12, 30));
      req_nib();
      check("nibble", nib_dout, exp_nib(b, k));
      check("done_pulse", done, (k == NNIB - 1) ? 1 : 0);
      check("underrun_hold", underrun, exp_ur);
    end
    exp_done++;
    tick(1);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("nibble_hold", nib_dout, exp_nib(b, NNIB - 1));
    check("done_count", done_cnt, exp_done);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_nib"}, nib_dout, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cs"}, rom_if.cs, 0);
    check({tag, "_addr"}, rom_if.addr, 0);
  endtask

  initial begin
    int b, b2, dc;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rstn = 1'b1;
    tick(2);

    // normal playback, one start carrying a same-cycle request
    for (int i = 0; i < 3; i++) begin
      rom_lat = $urandom_range(1, 4);
      b = $urandom_range(0, (1 << BW) - 1);
      do_start(b, i == 1, 1'b0);
      play(b, 0, 0);
    end

    // requests while idle are ignored
    req_nib();
    check("idle_req_hold", nib_dout, exp_nib(b, NNIB - 1));
    check("idle_req_done", done, 0);

    // starved requests right after start
    rom_lat = 2;
    b = 'h5;
    do_start(b, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      req_nib();
      check("starve_nib", nib_dout, 0);
      check("starve_underrun", underrun, 1);
    end
    play(b, 0, 1);

    // ok stuck high: the registered data lags one cycle behind each address
    force_ok = 1'b1;
    b = $urandom_range(0, (1 << BW) - 1);
    do_start(b, 1'b0, 1'b0);
    play(b, 0, 0);
    force_ok = 1'b0;

    // stop while the ROM read is pending
    rom_lat = $urandom_range(1, 4);
    b = $urandom_range(0, (1 << BW) - 1);
    do_start(b, 1'b0, 1'b0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_cs", rom_if.cs, 0);
    check("stop_busy", busy, 0);
    dc = done_cnt;
    tick(10);
    check("stop_no_done", done_cnt, dc);
    check("stop_still_idle", rom_if.cs, 0);
    b = $urandom_range(0, (1 << BW) - 1);
    do_start(b, 1'b0, 1'b0);
    play(b, 0, 0);

    // start and stop together while busy with underrun set
    b = $urandom_range(0, (1 << BW) - 1);
    do_start(b, 1'b0, 1'b0);
    req_nib();
    check("pre_restart_underrun", underrun, 1);
    tick(15);
    req_nib();
    check("pre_restart_nib0", nib_dout, exp_nib(b, 0));
    dc = done_cnt;
    b2 = 'h3;
    do_start(b2, 1'b0, 1'b1);
    check("restart_no_done", done_cnt, dc);
    play(b2, 0, 0);

    // reset in the middle of a segment
    b = $urandom_range(0, (1 << BW) - 1);
    do_start(b, 1'b0, 1'b0);
    tick(15);
    req_nib();
    check("mid_nib0", nib_dout, exp_nib(b, 0));
    tick(3);
    req_nib();
    check("mid_nib1", nib_dout, exp_nib(b, 1));
    rstn = 1'b0;
    tick(1);
    check_reset_values("midreset");
    rstn = 1'b1;
    tick(2);
    do_start(b, 1'b0, 1'b0);
    play(b, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
